id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register plus execute-side operand network; sits directly upstream of the ALU.
- Latches decoded operands and controls each cycle.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts bubbles; presents final A, B and aluctrl to the ALU.

Parameters:
- data_width, 32, operand and result width.
- addr_width, 5, register index width; register 0 is hardwired zero.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  decode holds a real instruction.
- id_rs1_addr, id_rs2_addr  input  addr_width  source register indices.
- id_rs1_data, id_rs2_data  input  data_width  register-file read data.
- id_imm  input  data_width  sign-extended immediate.
- id_use_imm  input  1  ALU B takes the immediate instead of rs2.
- id_aluctrl  input  4  ALU opcode (0001 ADD … 0111 SHIFTR; 0000 = nop).
- id_rd_addr  input  addr_width  destination register.
- id_reg_write, id_mem_read, id_mem_write  input  1  control bits.
- stall_in  input  1  downstream stall; hold stage contents.
- flush  input  1  branch/redirect kill.
- exmem_rd_addr  input  addr_width  EX/MEM destination.
- exmem_reg_write  input  1  EX/MEM writes a register.
- exmem_result  input  data_width  EX/MEM ALU result.
- memwb_rd_addr  input  addr_width  MEM/WB destination.
- memwb_reg_write  input  1  MEM/WB writes a register.
- memwb_result  input  data_width  MEM/WB write-back data.
- hazard_stall  output  1  load-use stall request to fetch/decode (combinational).
- alu_a, alu_b  output  data_width  forwarded operands to the ALU (combinational from registers).
- alu_ctrl  output  4  registered opcode; 0000 when the stage is invalid.
- store_data  output  data_width  forwarded rs2 value, pre-immediate mux.
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  output  1  registered controls, gated by valid.
- ex_rd_addr  output  addr_width  registered destination.

Behaviour:
- Reset (async, rst_n=0): every register clears to 0, so ex_valid=0, alu_ctrl=0000, all control outputs=0, ex_rd_addr=0. alu_a, alu_b and store_data evaluate to 0, and hazard_stall=0. Reset asserted mid-stall or mid-flush overrides both; the first edge after release loads normally.
- Register update priority per rising edge: flush > stall_in > hazard_stall > normal load.
  - flush=1: load a bubble (valid=0, all controls 0, aluctrl 0000, data registers 0). flush with stall_in=1 still bubbles.
  - stall_in=1 (no flush): hold every register unchanged.
  - hazard_stall=1: load a bubble; decode is expected to re-present the same instruction next cycle.
  - Otherwise: capture all id_* inputs. If id_valid=0, capture a bubble.
- Latency: an instruction accepted at edge N drives alu_a/alu_b/alu_ctrl during cycle N to N+1, so the ALU result is available the same cycle.
- Forwarding (combinational, per source, rs1 and rs2 independently):
  - Match EX/MEM when exmem_reg_write=1, exmem_rd_addr!=0 and exmem_rd_addr equals the registered rs index.
  - Else match MEM/WB under the same conditions.
  - Else use the registered register-file data.
  - EX/MEM has priority over MEM/WB when both match. An index of 0 never forwards.
- Operand outputs:
  - alu_a = forwarded rs1.
  - store_data = forwarded rs2.
  - alu_b = registered imm if use_imm, else forwarded rs2.
- hazard_stall = ex_valid & ex_mem_read & ex_rd_addr!=0 & id_valid & (rs1 match | rs2 match), where:
  - rs1 match = id_rs1_addr==ex_rd_addr.
  - rs2 match = id_rs2_addr==ex_rd_addr and (id_use_imm=0 or id_mem_write=1).
  - Forced to 0 when flush=1.
- Back-to-back loads, or a load followed by an unrelated instruction: no stall.
- Control outputs are registered values ANDed with ex_valid.

Test Plan:
- Reset with rst_n low mid-cycle while holding an instruction -> all outputs 0 immediately, no clk edge needed. Release, present ADD r3=r1+r2 (r1=5, r2=7) -> next cycle alu_a=5, alu_b=7, alu_ctrl=0001, ex_rd_addr=3.
- EX/MEM writes r1=0x10 and MEM/WB writes r1=0x20 while the stage holds r1+r2 with r2=7 -> alu_a=0x10 (EX/MEM priority), alu_b=7. Same scenario with rd=r0 -> no forward, alu_a=regfile value.
- Stage holds LW r4 (mem_read=1) while decode presents SUB r5=r4-r6 -> hazard_stall=1. Next edge: bubble (alu_ctrl=0000, ex_valid=0). With decode repeating the SUB and MEM/WB writing r4=0x99 -> hazard_stall=0 and the next edge captures SUB; alu_a=0x99.
- stall_in held 3 cycles with ADD in the stage and new decode inputs changing -> outputs unchanged for 3 cycles, then the new instruction is captured on the first edge after release.
- flush and stall_in asserted together with a valid OR in decode -> next edge gives ex_valid=0, alu_ctrl=0000, and hazard_stall=0 that cycle.
- Store SW with use_imm=1, imm=8, rs2=r7 forwarded from MEM/WB=0xABCD -> alu_b=8, store_data=0xABCD, ex_mem_write=1.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding,
// load-use hazard detection and bubble insertion; feeds the ALU directly.
// Ports: clk/rst_n; id_* decoded instruction; stall_in/flush controls;
//        exmem_*/memwb_* forwarding sources; hazard_stall to fetch/decode;
//        alu_a/alu_b/alu_ctrl/store_data and ex_* registered controls out.
module id_ex_stage #(
  parameter int data_width = 32,
  parameter int addr_width = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [addr_width-1:0] id_rs1_addr,
  input  logic [addr_width-1:0] id_rs2_addr,
  input  logic [data_width-1:0] id_rs1_data,
  input  logic [data_width-1:0] id_rs2_data,
  input  logic [data_width-1:0] id_imm,
  input  logic                  id_use_imm,
  input  logic [3:0]            id_aluctrl,
  input  logic [addr_width-1:0] id_rd_addr,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  stall_in,
  input  logic                  flush,
  input  logic [addr_width-1:0] exmem_rd_addr,
  input  logic                  exmem_reg_write,
  input  logic [data_width-1:0] exmem_result,
  input  logic [addr_width-1:0] memwb_rd_addr,
  input  logic                  memwb_reg_write,
  input  logic [data_width-1:0] memwb_result,
  output logic                  hazard_stall,
  output logic [data_width-1:0] alu_a,
  output logic [data_width-1:0] alu_b,
  output logic [3:0]            alu_ctrl,
  output logic [data_width-1:0] store_data,
  output logic                  ex_valid,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic [addr_width-1:0] ex_rd_addr
);

  typedef struct packed {
    logic                  valid;
    logic [addr_width-1:0] rs1;
    logic [addr_width-1:0] rs2;
    logic [data_width-1:0] rs1_data;
    logic [data_width-1:0] rs2_data;
    logic [data_width-1:0] imm;
    logic                  use_imm;
    logic [3:0]            ctrl;
    logic [addr_width-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } id_ex_t;

  id_ex_t q;
  id_ex_t d;

  always_comb begin
    d           = '0;
    d.valid     = 1'b1;
    d.rs1       = id_rs1_addr;
    d.rs2       = id_rs2_addr;
    d.rs1_data  = id_rs1_data;
    d.rs2_data  = id_rs2_data;
    d.imm       = id_imm;
    d.use_imm   = id_use_imm;
    d.ctrl      = id_aluctrl;
    d.rd        = id_rd_addr;
    d.reg_write = id_reg_write;
    d.mem_read  = id_mem_read;
    d.mem_write = id_mem_write;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (!stall_in) begin
      if (hazard_stall || !id_valid) begin
        q <= '0;
      end else begin
        q <= d;
      end
    end
  end

  // x0 is never a forwarding target; EX/MEM wins over MEM/WB.
  logic ex_ok;
  logic wb_ok;
  logic ex1;
  logic wb1;
  logic ex2;
  logic wb2;

  assign ex_ok = exmem_reg_write && (exmem_rd_addr != '0);
  assign wb_ok = memwb_reg_write && (memwb_rd_addr != '0);
  assign ex1   = ex_ok && (exmem_rd_addr == q.rs1);
  assign wb1   = wb_ok && (memwb_rd_addr == q.rs1) && !ex1;
  assign ex2   = ex_ok && (exmem_rd_addr == q.rs2);
  assign wb2   = wb_ok && (memwb_rd_addr == q.rs2) && !ex2;

  logic [data_width-1:0] fwd1;
  logic [data_width-1:0] fwd2;

  always_comb begin
    fwd1 = q.rs1_data;
    unique case (1'b1)
      ex1:     fwd1 = exmem_result;
      wb1:     fwd1 = memwb_result;
      default: fwd1 = q.rs1_data;
    endcase
  end

  always_comb begin
    fwd2 = q.rs2_data;
    unique case (1'b1)
      ex2:     fwd2 = exmem_result;
      wb2:     fwd2 = memwb_result;
      default: fwd2 = q.rs2_data;
    endcase
  end

  assign alu_a      = fwd1;
  assign store_data = fwd2;
  assign alu_b      = q.use_imm ? q.imm : fwd2;

  // rs2 only matters to an imm-form op when it is a store's data.
  logic ld_in_ex;
  logic rs1_hit;
  logic rs2_hit;

  assign ld_in_ex = q.valid && q.mem_read && (q.rd != '0);
  assign rs1_hit  = (id_rs1_addr == q.rd);
  assign rs2_hit  = (id_rs2_addr == q.rd)
                  && (!id_use_imm || id_mem_write);

  assign hazard_stall = ld_in_ex && id_valid
                      && (rs1_hit || rs2_hit) && !flush;

  assign ex_valid     = q.valid;
  assign alu_ctrl     = q.valid ? q.ctrl : 4'b0000;
  assign ex_reg_write = q.valid && q.reg_write;
  assign ex_mem_read  = q.valid && q.mem_read;
  assign ex_mem_write = q.valid && q.mem_write;
  assign ex_rd_addr   = q.rd;

endmodule
